// File: rtl/alu_issue_wb.sv
// Issue FIFO and writeback register around the combinational integer ALU.
// The FIFO head feeds the ALU, and the ALU result is registered for the scoreboard.
package config_pkg;
  typedef struct packed {
    int unsigned XLEN;
    int unsigned TRANS_ID_BITS;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{XLEN: 32, TRANS_ID_BITS: 4};

  localparam int unsigned FU_XLEN  = cva6_cfg_empty.XLEN;
  localparam int unsigned FU_TID_W = cva6_cfg_empty.TRANS_ID_BITS;

  typedef enum logic [3:0] {
    ADD = 4'd0,
    SUB = 4'd1,
    EQ  = 4'd2,
    NE  = 4'd3
  } fu_op;

  typedef struct packed {
    fu_op                operation;
    logic [FU_XLEN-1:0]  operand_a;
    logic [FU_XLEN-1:0]  operand_b;
    logic [FU_XLEN-1:0]  imm;
    logic [FU_TID_W-1:0] trans_id;
  } fu_data_t;
endpackage

module alu_issue_wb #(
  parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
  parameter int unsigned           DEPTH   = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                flush_i,
  input  logic                                issue_valid_i,
  output logic                                issue_ready_o,
  input  config_pkg::fu_data_t                issue_data_i,
  output config_pkg::fu_data_t                alu_fu_data_o,
  input  logic [CVA6Cfg.XLEN-1:0]             alu_result_i,
  input  logic                                alu_branch_res_i,
  output logic                                wb_valid_o,
  input  logic                                wb_ready_i,
  output logic [CVA6Cfg.XLEN-1:0]             wb_result_o,
  output logic                                wb_branch_res_o,
  output logic [CVA6Cfg.TRANS_ID_BITS-1:0]    wb_trans_id_o,
  output logic [$clog2(DEPTH):0]              occupancy_o
);
  localparam int unsigned       PTR_W = $clog2(DEPTH);
  localparam int unsigned       CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  FULL  = CNT_W'(DEPTH);

  config_pkg::fu_data_t                mem_q [DEPTH];
  logic [PTR_W-1:0]                    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]                    count_q, count_d;
  logic                                wb_valid_q, wb_valid_d;
  logic                                wb_branch_q, wb_branch_d;
  logic [CVA6Cfg.XLEN-1:0]             wb_result_q, wb_result_d;
  logic [CVA6Cfg.TRANS_ID_BITS-1:0]    wb_trans_id_q, wb_trans_id_d;
  logic                                push, pop;

  // Ready looks only at the stored count and flush, never at the writeback side.
  assign issue_ready_o = (count_q != FULL) & ~flush_i;
  assign push          = issue_valid_i & issue_ready_o;
  assign pop           = (count_q != '0) & (~wb_valid_q | wb_ready_i) & ~flush_i;
  assign alu_fu_data_o = (count_q != '0) ? mem_q[rptr_q] : '0;

  always_comb begin
    wptr_d        = wptr_q;
    rptr_d        = rptr_q;
    count_d       = count_q;
    wb_valid_d    = wb_valid_q;
    wb_result_d   = wb_result_q;
    wb_branch_d   = wb_branch_q;
    wb_trans_id_d = wb_trans_id_q;
    if (flush_i) begin
      wptr_d     = '0;
      rptr_d     = '0;
      count_d    = '0;
      wb_valid_d = 1'b0;
    end else begin
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop) begin
        rptr_d        = rptr_q + 1'b1;
        wb_valid_d    = 1'b1;
        wb_result_d   = alu_result_i;
        wb_branch_d   = alu_branch_res_i;
        wb_trans_id_d = alu_fu_data_o.trans_id;
      end else if (wb_ready_i) begin
        wb_valid_d = 1'b0;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q        <= '0;
      rptr_q        <= '0;
      count_q       <= '0;
      wb_valid_q    <= 1'b0;
      wb_result_q   <= '0;
      wb_branch_q   <= 1'b0;
      wb_trans_id_q <= '0;
    end else begin
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      count_q       <= count_d;
      wb_valid_q    <= wb_valid_d;
      wb_result_q   <= wb_result_d;
      wb_branch_q   <= wb_branch_d;
      wb_trans_id_q <= wb_trans_id_d;
    end
  end

  // Payload storage is left untouched by reset and flush; the pointers decide what is live.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= issue_data_i;
  end

  assign wb_valid_o      = wb_valid_q;
  assign wb_result_o     = wb_result_q;
  assign wb_branch_res_o = wb_branch_q;
  assign wb_trans_id_o   = wb_trans_id_q;
  assign occupancy_o     = count_q;
endmodule

// File: tb/tb_alu_issue_wb.sv
// Bench for alu_issue_wb: table-driven vectors plus scoreboarded multi-cycle sequences.
module tb_alu_issue_wb;
  import config_pkg::*;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] res;
    logic        br;
    logic [3:0]  tid;
  } exp_t;

  typedef struct {
    fu_op        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tid;
    logic [31:0] res;
    logic        br;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b1;
  logic        flush_i = 1'b0;
  logic        issue_valid_i = 1'b0;
  logic        issue_ready_o;
  fu_data_t    issue_data_i = '0;
  fu_data_t    alu_fu_data_o;
  logic [31:0] alu_result_i;
  logic        alu_branch_res_i;
  logic        wb_valid_o;
  logic        wb_ready_i = 1'b0;
  logic [31:0] wb_result_o;
  logic        wb_branch_res_o;
  logic [3:0]  wb_trans_id_o;
  logic [2:0]  occupancy_o;

  exp_t  sb[$];
  exp_t  cur_exp;
  vec_t  vecs[6];
  bit    last_acc;
  bit    tog;
  int    checks = 0;
  int    failures = 0;

  alu_issue_wb #(.CVA6Cfg(cva6_cfg_empty), .DEPTH(DEPTH)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .flush_i          (flush_i),
    .issue_valid_i    (issue_valid_i),
    .issue_ready_o    (issue_ready_o),
    .issue_data_i     (issue_data_i),
    .alu_fu_data_o    (alu_fu_data_o),
    .alu_result_i     (alu_result_i),
    .alu_branch_res_i (alu_branch_res_i),
    .wb_valid_o       (wb_valid_o),
    .wb_ready_i       (wb_ready_i),
    .wb_result_o      (wb_result_o),
    .wb_branch_res_o  (wb_branch_res_o),
    .wb_trans_id_o    (wb_trans_id_o),
    .occupancy_o      (occupancy_o)
  );

  always #5 clk = ~clk;

  // Stand-in ALU: sum of operands, branch compare for EQ/NE.
  always_comb begin
    alu_result_i     = alu_fu_data_o.operand_a + alu_fu_data_o.operand_b;
    alu_branch_res_i = 1'b0;
    case (alu_fu_data_o.operation)
      EQ:      alu_branch_res_i = (alu_fu_data_o.operand_a == alu_fu_data_o.operand_b);
      NE:      alu_branch_res_i = (alu_fu_data_o.operand_a != alu_fu_data_o.operand_b);
      default: alu_branch_res_i = 1'b0;
    endcase
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_issue(input fu_op op, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] tid, input logic [31:0] res, input logic br);
    issue_data_i           = '0;
    issue_data_i.operation = op;
    issue_data_i.operand_a = a;
    issue_data_i.operand_b = b;
    issue_data_i.trans_id  = tid;
    cur_exp.res = res;
    cur_exp.br  = br;
    cur_exp.tid = tid;
  endtask

  // Called at a negedge with inputs already driven; advances to the next negedge.
  task automatic step();
    exp_t e;
    #1;
    last_acc = issue_valid_i && issue_ready_o;
    if (last_acc) sb.push_back(cur_exp);
    if (wb_valid_o && wb_ready_i) begin
      if (sb.size() == 0) begin
        chk("wb_unexpected", {60'd0, wb_trans_id_o}, 64'hFFFF);
      end else begin
        e = sb.pop_front();
        chk("wb_result", wb_result_o, e.res);
        chk("wb_branch", wb_branch_res_o, e.br);
        chk("wb_trans_id", wb_trans_id_o, e.tid);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input bit toggle_ready);
    issue_valid_i = 1'b1;
    last_acc = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (toggle_ready) begin
        wb_ready_i = tog;
        tog = ~tog;
      end
      step();
      if (last_acc) break;
    end
    chk("issue_accepted", last_acc, 1'b1);
    issue_valid_i = 1'b0;
  endtask

  task automatic drain();
    issue_valid_i = 1'b0;
    wb_ready_i = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (sb.size() == 0 && !wb_valid_o) break;
      step();
    end
    chk("drain_sb_empty", sb.size(), 0);
    chk("drain_wb_idle", wb_valid_o, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{ADD, 32'd5,        32'd7,        4'd3, 32'd12,        1'b0};
    vecs[1] = '{EQ,  32'h1234,     32'h1234,     4'd1, 32'h2468,      1'b1};
    vecs[2] = '{NE,  32'h1234,     32'h1234,     4'd2, 32'h2468,      1'b0};
    vecs[3] = '{EQ,  32'd1,        32'd2,        4'd4, 32'd3,         1'b0};
    vecs[4] = '{NE,  32'd1,        32'd2,        4'd5, 32'd3,         1'b1};
    vecs[5] = '{ADD, 32'hFFFFFFFF, 32'd1,        4'd6, 32'd0,         1'b0};

    // Reset state
    #1 rst_ni = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_wb_valid", wb_valid_o, 1'b0);
    chk("rst_occupancy", occupancy_o, 0);
    chk("rst_wb_result", wb_result_o, 0);
    chk("rst_wb_branch", wb_branch_res_o, 1'b0);
    chk("rst_wb_tid", wb_trans_id_o, 0);
    chk("rst_head_zero", alu_fu_data_o, 0);
    rst_ni = 1'b1;
    #1 chk("rst_issue_ready", issue_ready_o, 1'b1);
    @(negedge clk);

    // Single ADD latency
    wb_ready_i = 1'b1;
    set_issue(ADD, 32'd5, 32'd7, 4'd3, 32'd12, 1'b0);
    issue(1'b0);
    chk("lat_wb_not_yet", wb_valid_o, 1'b0);
    chk("lat_occ_one", occupancy_o, 1);
    step();
    chk("lat_wb_valid", wb_valid_o, 1'b1);
    chk("lat_wb_result", wb_result_o, 12);
    chk("lat_wb_tid", wb_trans_id_o, 3);
    chk("lat_occ_zero", occupancy_o, 0);
    step();
    chk("lat_one_cycle", wb_valid_o, 1'b0);
    drain();

    // Table-driven back-to-back vectors
    wb_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tid, vecs[i].res, vecs[i].br);
      issue(1'b0);
    end
    drain();

    // Backpressure fill
    wb_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_issue(ADD, 32'(i * 10), 32'd1, 4'(i), 32'(i * 10 + 1), 1'b0);
      issue(1'b0);
    end
    chk("full_occ", occupancy_o, 4);
    chk("full_ready_low", issue_ready_o, 1'b0);
    chk("full_wb_valid", wb_valid_o, 1'b1);
    chk("full_wb_tid0", wb_trans_id_o, 0);
    set_issue(ADD, 32'd50, 32'd1, 4'd5, 32'd51, 1'b0);
    issue_valid_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("full_hold_rejected", last_acc, 1'b0);
      chk("full_hold_wb_tid", wb_trans_id_o, 0);
    end
    chk("full_hold_occ", occupancy_o, 4);
    wb_ready_i = 1'b1;
    issue(1'b0);
    drain();

    // Flush with buffered entries and a pending writeback
    wb_ready_i = 1'b0;
    for (int i = 8; i < 12; i++) begin
      set_issue(SUB, 32'(i), 32'd2, 4'(i), 32'(i + 2), 1'b0);
      issue(1'b0);
    end
    chk("pre_flush_occ", occupancy_o, 3);
    chk("pre_flush_wb", wb_valid_o, 1'b1);
    set_issue(ADD, 32'd1, 32'd1, 4'd12, 32'd2, 1'b0);
    flush_i = 1'b1;
    issue_valid_i = 1'b1;
    step();
    chk("flush_req_rejected", last_acc, 1'b0);
    flush_i = 1'b0;
    issue_valid_i = 1'b0;
    chk("flush_occ", occupancy_o, 0);
    chk("flush_wb_valid", wb_valid_o, 1'b0);
    chk("flush_head_zero", alu_fu_data_o, 0);
    sb.delete();
    wb_ready_i = 1'b1;
    step();
    step();
    set_issue(ADD, 32'd20, 32'd22, 4'd13, 32'd42, 1'b0);
    issue(1'b0);
    drain();

    // Wrap-around stream with toggling writeback ready
    tog = 1'b1;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      set_issue(ADD, 32'(i * 3), 32'd100, 4'(i), 32'(i * 3 + 100), 1'b0);
      issue(1'b1);
    end
    drain();

    // Asynchronous reset while full
    wb_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_issue(ADD, 32'(i), 32'd7, 4'(i + 2), 32'(i + 7), 1'b0);
      issue(1'b0);
    end
    chk("mrst_pre_occ", occupancy_o, 4);
    #2 rst_ni = 1'b0;
    #1;
    chk("mrst_occ", occupancy_o, 0);
    chk("mrst_wb_valid", wb_valid_o, 1'b0);
    chk("mrst_wb_result", wb_result_o, 0);
    chk("mrst_wb_tid", wb_trans_id_o, 0);
    chk("mrst_wb_branch", wb_branch_res_o, 1'b0);
    chk("mrst_head_zero", alu_fu_data_o, 0);
    sb.delete();
    @(negedge clk);
    rst_ni = 1'b1;
    #1 chk("mrst_ready_after", issue_ready_o, 1'b1);
    @(negedge clk);
    wb_ready_i = 1'b1;
    set_issue(ADD, 32'd9, 32'd9, 4'd7, 32'd18, 1'b0);
    issue(1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_issue_wb.md
# alu_issue_wb

Issue-buffer and writeback-register stage that sits on both ends of the integer ALU. It accepts `fu_data_t` issue requests through a valid/ready handshake and buffers them in a small in-order FIFO. The FIFO head drives the ALU's `fu_data_i`; the block captures the ALU's combinational `result_o` and `alu_branch_res_o` together with the head `trans_id` into a writeback register. The writeback register presents results to the scoreboard under valid/ready backpressure and supports a pipeline flush.

## Interface
- `CVA6Cfg`, default `config_pkg::cva6_cfg_empty`: core configuration. Supplies `riscv::XLEN` and `TRANS_ID_BITS`.
- `DEPTH`, default 4: number of FIFO entries. Must be a power of two, 2 or greater.
- `clk_i` input, 1 bit: the single clock.
- `rst_ni` input, 1 bit: reset, asynchronous and active-low.
- `flush_i` input, 1 bit: synchronous flush of all buffered and writeback state.
- `issue_valid_i` input, 1 bit: an issue request is present.
- `issue_ready_o` output, 1 bit: the block can accept an issue request.
- `issue_data_i` input, `fu_data_t`: operation, operands and `trans_id`.
- `alu_fu_data_o` output, `fu_data_t`: FIFO head, driven to the ALU.
- `alu_result_i` input, XLEN bits: ALU result for `alu_fu_data_o`.
- `alu_branch_res_i` input, 1 bit: ALU branch comparison result.
- `wb_valid_o` output, 1 bit: the writeback register holds a result.
- `wb_ready_i` input, 1 bit: the consumer accepts the writeback result.
- `wb_result_o` output, XLEN bits: registered result.
- `wb_branch_res_o` output, 1 bit: registered branch result.
- `wb_trans_id_o` output, `TRANS_ID_BITS` bits: registered transaction id.
- `occupancy_o` output, `$clog2(DEPTH)+1` bits: current number of FIFO entries.

## Operation
- **FIFO storage:** `DEPTH` entries of `fu_data_t`, plus a write pointer, a read pointer and a count.
  - Pointers are `$clog2(DEPTH)` bits wide and wrap modulo `DEPTH`.
  - `occupancy_o` equals the count.
- **Push:** `push = issue_valid_i & issue_ready_o`.
  - `issue_ready_o = (count != DEPTH) & ~flush_i`. This is registered-state only; there is no combinational path from `wb_ready_i`.
  - When the FIFO is full, `issue_ready_o` is low even if a pop happens in the same cycle.
- **Head:** `alu_fu_data_o` is the entry at the read pointer when count > 0, and all-zero otherwise.
- **Pop:** `pop = (count != 0) & (~wb_valid_o | wb_ready_i) & ~flush_i`.
  - On pop, the writeback register loads `alu_result_i`, `alu_branch_res_i` and `alu_fu_data_o.trans_id`, and `wb_valid_o` is set.
- **Writeback drain:** on `wb_ready_i & wb_valid_o` with no pop, `wb_valid_o` clears.
  - While `wb_valid_o` is high and `wb_ready_i` is low, all `wb_*` outputs hold stable.
- **Count update:** push and pop in the same cycle leave the count unchanged. Push alone increments it; pop alone decrements it.
- **Ordering:** strictly in-order, with no bypass from issue to ALU. Results leave in issue order.
- **Flush (takes priority over everything):**
  - Next cycle: count = 0, both pointers = 0, `wb_valid_o` = 0.
  - A request presented during flush is not accepted.
  - Stored FIFO data is not cleared.
- **Reset:**
  - count, pointers and `wb_valid_o` are 0.
  - `wb_result_o`, `wb_branch_res_o` and `wb_trans_id_o` are 0.
  - `issue_ready_o` is 1 once `rst_ni` deasserts.
  - Asserting reset mid-operation discards all entries asynchronously.

## Timing
- All state updates on the rising edge of `clk_i`; asynchronous clear on `rst_ni` low.
- **Issue-to-writeback latency:** request accepted at edge N; entry at head in cycle N+1; `wb_valid_o` high from edge N+1 with no backpressure. That is 2 cycles from `issue_valid_i` to `wb_valid_o`.
- **Sustained throughput:** 1 result per cycle when `wb_ready_i` is held high and issue is continuous.
- **Ready path:** `issue_ready_o` depends only on count and `flush_i`.
- **ALU timing path:** the path `alu_fu_data_o` → ALU → `alu_result_i` → writeback register is a single-cycle combinational path by design.
- **Boundary conditions:**
  - Empty FIFO: no pop, and `wb_valid_o` drains normally.
  - Full FIFO with writeback stalled: holds indefinitely.
  - Pointer wrap after `DEPTH` pushes returns to entry 0.

## Test plan
- **Single ADD:** after reset, issue ADD with a=5, b=7, trans_id=3, and `wb_ready_i`=1. Required: `wb_valid_o` high two cycles later for one cycle, with `wb_result_o`=12 and `wb_trans_id_o`=3.
- **Backpressure fill:** hold `wb_ready_i`=0 and issue 6 back-to-back ADDs.
  - First result captured; `occupancy_o` reaches 4 and `issue_ready_o` drops.
  - The 6th request is held until `wb_ready_i` rises.
  - Then all results appear in order with trans_id 0..5.
- **Branch result:** issue EQ with a=b=0x1234. Required: `wb_branch_res_o`=1. Then issue NE with the same operands. Required: `wb_branch_res_o`=0.
- **Flush:** with 3 entries buffered and `wb_valid_o`=1, assert `flush_i` for one cycle while `issue_valid_i`=1.
  - Next cycle: `occupancy_o`=0 and `wb_valid_o`=0.
  - The flush-cycle request is not accepted.
- **Wrap-around:** stream 3×DEPTH requests with `wb_ready_i` toggling 1,0,1,0. Required: every trans_id is returned exactly once, in order, with no loss or duplication.
- **Mid-operation reset:** pulse `rst_ni` low between edges while the FIFO is full. Required: all outputs go to their reset values immediately, and `issue_ready_o` is 1 after release.
